// File: rtl/burst_addr_gen.sv
// Burst address generator: holds start/length registers, issues one address per enabled beat,
// and pulses stop_signal on the final beat. Single-transfer addresses pass through when idle.
module burst_addr_gen #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned LEN_W     = 8,
  parameter int unsigned ADDR_STEP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] initial_addr_in,
  input  logic              initial_addr_reg_wen,
  input  logic [LEN_W-1:0]  burst_len_in,
  input  logic              initial_burst_len_reg_en,
  input  logic [ADDR_W-1:0] single_addr_in,
  input  logic              addr_sel,
  input  logic              counter_en,
  input  logic              adder_en,
  output logic [ADDR_W-1:0] addr_out,
  output logic              addr_valid,
  output logic              stop_signal,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [ADDR_W-1:0] Step   = ADDR_W'(ADDR_STEP);
  localparam logic [LEN_W-1:0]  LenOne = LEN_W'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] start_q, start_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [ADDR_W-1:0] addr_out_q, addr_out_d;
  logic              addr_valid_q, addr_valid_d;
  logic              stop_q, stop_d;
  logic [ADDR_W-1:0] eff_start;
  logic [LEN_W-1:0]  eff_len;

  always_comb begin
    // A load in the same cycle as a start is used by that start.
    eff_start    = initial_addr_reg_wen ? initial_addr_in : start_q;
    eff_len      = initial_burst_len_reg_en ? burst_len_in : len_q;
    state_d      = state_q;
    start_d      = start_q;
    len_d        = len_q;
    cur_addr_d   = cur_addr_q;
    beat_cnt_d   = beat_cnt_q;
    addr_out_d   = addr_out_q;
    addr_valid_d = 1'b0;
    stop_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        start_d = eff_start;
        len_d   = eff_len;
        if (!addr_sel) begin
          addr_out_d = single_addr_in;
        end else if (counter_en) begin
          cur_addr_d = eff_start;
          beat_cnt_d = '0;
          if (eff_len == '0) begin
            state_d = StDone;
            stop_d  = 1'b1;
          end else begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (!addr_sel) begin
          state_d = StIdle;
        end else if (adder_en) begin
          addr_out_d   = cur_addr_q;
          addr_valid_d = 1'b1;
          cur_addr_d   = cur_addr_q + Step;
          beat_cnt_d   = beat_cnt_q + LenOne;
          if (beat_cnt_q == len_q - LenOne) begin
            stop_d  = 1'b1;
            state_d = StDone;
          end
        end
      end
      StDone: begin
        // Held request parks here so it cannot retrigger a burst.
        if (!counter_en) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      start_q      <= '0;
      len_q        <= '0;
      cur_addr_q   <= '0;
      beat_cnt_q   <= '0;
      addr_out_q   <= '0;
      addr_valid_q <= 1'b0;
      stop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_q      <= start_d;
      len_q        <= len_d;
      cur_addr_q   <= cur_addr_d;
      beat_cnt_q   <= beat_cnt_d;
      addr_out_q   <= addr_out_d;
      addr_valid_q <= addr_valid_d;
      stop_q       <= stop_d;
    end
  end

  assign addr_out    = addr_out_q;
  assign addr_valid  = addr_valid_q;
  assign stop_signal = stop_q;
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_burst_addr_gen.sv
// Bench for burst_addr_gen: directed scenarios with literal expectations plus a randomized run,
// all checked every cycle against a beat-counting reference model.
module tb_burst_addr_gen;
  localparam int ADDR_W    = 16;
  localparam int LEN_W     = 8;
  localparam int ADDR_STEP = 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ADDR_W-1:0] initial_addr_in = '0;
  logic              initial_addr_reg_wen = 1'b0;
  logic [LEN_W-1:0]  burst_len_in = '0;
  logic              initial_burst_len_reg_en = 1'b0;
  logic [ADDR_W-1:0] single_addr_in = '0;
  logic              addr_sel = 1'b0;
  logic              counter_en = 1'b0;
  logic              adder_en = 1'b0;
  logic [ADDR_W-1:0] addr_out;
  logic              addr_valid;
  logic              stop_signal;
  logic              busy;

  burst_addr_gen #(
    .ADDR_W   (ADDR_W),
    .LEN_W    (LEN_W),
    .ADDR_STEP(ADDR_STEP)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .initial_addr_in         (initial_addr_in),
    .initial_addr_reg_wen    (initial_addr_reg_wen),
    .burst_len_in            (burst_len_in),
    .initial_burst_len_reg_en(initial_burst_len_reg_en),
    .single_addr_in          (single_addr_in),
    .addr_sel                (addr_sel),
    .counter_en              (counter_en),
    .adder_en                (adder_en),
    .addr_out                (addr_out),
    .addr_valid              (addr_valid),
    .stop_signal             (stop_signal),
    .busy                    (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit checking = 1'b0;

  logic [ADDR_W-1:0] beat_q[$];
  int                stop_cnt = 0;
  logic [ADDR_W-1:0] last_stop_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a burst is "start address plus beats issued so far"; it is either
  // running, finished (waiting for request release), or neither.
  logic [ADDR_W-1:0] m_start = '0, m_base = '0, m_addr = '0;
  int unsigned       m_len = 0, m_issued = 0;
  bit                m_running = 0, m_finished = 0;
  logic              m_valid = 0, m_stop = 0;
  logic [ADDR_W-1:0] m_eff_start;
  int unsigned       m_eff_len;

  task automatic model_step();
    if (rst) begin
      m_start = '0; m_base = '0; m_addr = '0; m_len = 0; m_issued = 0;
      m_running = 0; m_finished = 0; m_valid = 0; m_stop = 0;
      return;
    end
    m_valid = 0;
    m_stop  = 0;
    if (m_finished) begin
      if (!counter_en) m_finished = 0;
    end else if (m_running) begin
      if (!addr_sel) begin
        m_running = 0;
      end else if (adder_en) begin
        m_addr  = ADDR_W'(int'(m_base) + int'(m_issued) * ADDR_STEP);
        m_valid = 1;
        m_issued++;
        if (m_issued == m_len) begin
          m_stop = 1; m_running = 0; m_finished = 1;
        end
      end
    end else begin
      m_eff_start = initial_addr_reg_wen ? initial_addr_in : m_start;
      m_eff_len   = initial_burst_len_reg_en ? int'(burst_len_in) : m_len;
      m_start     = m_eff_start;
      m_len       = m_eff_len;
      if (!addr_sel) begin
        m_addr = single_addr_in;
      end else if (counter_en) begin
        m_base   = m_eff_start;
        m_issued = 0;
        if (m_eff_len == 0) begin
          m_stop = 1; m_finished = 1;
        end else begin
          m_running = 1;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (checking) begin
      check("cycle {addr,valid,stop,busy}",
            32'({addr_out, addr_valid, stop_signal, busy}),
            32'({m_addr, m_valid, m_stop, (m_running || m_finished)}));
      if (addr_valid) beat_q.push_back(addr_out);
      if (stop_signal) begin
        stop_cnt++;
        last_stop_addr = addr_out;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    beat_q.delete();
    stop_cnt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    counter_en = 0; adder_en = 0; addr_sel = 0;
    initial_addr_reg_wen = 0; initial_burst_len_reg_en = 0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic load(input logic [ADDR_W-1:0] s, input logic [LEN_W-1:0] l);
    counter_en = 0; addr_sel = 1; adder_en = 1;
    initial_addr_in = s; initial_addr_reg_wen = 1;
    burst_len_in = l; initial_burst_len_reg_en = 1;
    tick();
    initial_addr_reg_wen = 0; initial_burst_len_reg_en = 0;
  endtask

  task automatic wait_beats(input string name, input int n, input int max_cycles);
    for (int i = 0; i < max_cycles && beat_q.size() < n; i++) tick();
    check(name, 32'(beat_q.size() >= n), 32'd1);
  endtask

  task automatic wait_stop(input string name, input int max_cycles);
    for (int i = 0; i < max_cycles && stop_cnt == 0; i++) tick();
    check(name, 32'(stop_cnt), 32'd1);
  endtask

  task automatic check_beats(input string name, input logic [ADDR_W-1:0] base, input int n);
    logic [ADDR_W-1:0] exp_a;
    check({name, " beat count"}, 32'(beat_q.size()), 32'(n));
    for (int i = 0; i < n && i < beat_q.size(); i++) begin
      exp_a = ADDR_W'(int'(base) + i * ADDR_STEP);
      check({name, " beat addr"}, 32'(beat_q[i]), 32'(exp_a));
    end
  endtask

  initial begin
    do_reset();
    checking = 1'b1;
    check("reset outputs", 32'({addr_out, addr_valid, stop_signal, busy}), 32'd0);

    // Basic burst
    clear_log();
    load(16'h0100, 8'd4);
    counter_en = 1;
    tick();
    check("basic E0 busy/valid", 32'({busy, addr_valid}), 32'b10);
    tick();
    check("basic first beat", 32'({addr_out, addr_valid}), 32'({16'h0100, 1'b1}));
    wait_stop("basic stop", 10);
    check_beats("basic", 16'h0100, 4);
    check("basic stop addr", 32'(last_stop_addr), 32'h0103);
    tick();
    check("basic done holds", 32'({busy, stop_signal}), 32'b10);
    counter_en = 0;
    tick();
    check("basic idle", 32'(busy), 32'd0);

    // Wrap and stall
    clear_log();
    load(16'hFFFE, 8'd3);
    counter_en = 1;
    tick();
    tick();
    check("wrap first beat", 32'({addr_out, addr_valid}), 32'({16'hFFFE, 1'b1}));
    adder_en = 0;
    tick();
    check("stall 1", 32'({addr_out, addr_valid}), 32'({16'hFFFE, 1'b0}));
    tick();
    check("stall 2", 32'({addr_out, addr_valid}), 32'({16'hFFFE, 1'b0}));
    adder_en = 1;
    wait_stop("wrap stop", 10);
    check_beats("wrap", 16'hFFFE, 3);
    check("wrap stop addr", 32'(last_stop_addr), 32'h0000);
    counter_en = 0;
    tick();

    // Zero length
    clear_log();
    load(16'h0042, 8'd0);
    counter_en = 1;
    tick();
    check("zero stop/valid/busy", 32'({stop_signal, addr_valid, busy}), 32'b101);
    tick();
    check("zero pulse ends", 32'({stop_signal, busy}), 32'b01);
    tick();
    check("zero busy held", 32'(busy), 32'd1);
    counter_en = 0;
    tick();
    check("zero idle", 32'(busy), 32'd0);
    check("zero no beats", 32'(beat_q.size()), 32'd0);

    // Single mode, then bypass start
    clear_log();
    addr_sel = 0; single_addr_in = 16'h1234; counter_en = 1;
    tick();
    check("single addr", 32'({addr_out, addr_valid, busy}), 32'({16'h1234, 2'b00}));
    tick();
    check("single ignores start", 32'(busy), 32'd0);
    addr_sel = 1;
    initial_addr_in = 16'h0500; initial_addr_reg_wen = 1;
    burst_len_in = 8'd2; initial_burst_len_reg_en = 1;
    tick();
    initial_addr_reg_wen = 0; initial_burst_len_reg_en = 0;
    wait_stop("bypass stop", 10);
    check_beats("bypass", 16'h0500, 2);
    counter_en = 0;
    tick();

    // Abort after beat 3
    clear_log();
    load(16'h2000, 8'd10);
    counter_en = 1;
    wait_beats("abort wait", 3, 10);
    addr_sel = 0;
    tick();
    check("abort idle", 32'({busy, addr_valid, stop_signal}), 32'b000);
    check("abort beats", 32'(beat_q.size()), 32'd3);
    check("abort no stop", 32'(stop_cnt), 32'd0);
    clear_log();
    load(16'h3000, 8'd2);
    counter_en = 1;
    wait_stop("after abort stop", 10);
    check_beats("after abort", 16'h3000, 2);
    counter_en = 0;
    tick();

    // Reset after beat 5
    clear_log();
    load(16'h4000, 8'd10);
    counter_en = 1;
    wait_beats("reset wait", 5, 12);
    rst = 1;
    tick();
    check("mid reset outputs", 32'({addr_out, addr_valid, stop_signal, busy}), 32'd0);
    check("mid reset no stop", 32'(stop_cnt), 32'd0);
    rst = 0; counter_en = 0;
    tick();

    // Locked registers during RUN
    clear_log();
    load(16'h0700, 8'd3);
    counter_en = 1;
    tick();
    initial_addr_in = 16'h0900; initial_addr_reg_wen = 1;
    burst_len_in = 8'd5; initial_burst_len_reg_en = 1;
    tick();
    initial_addr_reg_wen = 0; initial_burst_len_reg_en = 0;
    wait_stop("locked stop", 10);
    check_beats("locked", 16'h0700, 3);
    counter_en = 0;
    tick();
    clear_log();
    counter_en = 1;
    wait_stop("locked rerun stop", 10);
    check_beats("locked rerun", 16'h0700, 3);
    counter_en = 0;
    tick();

    // Randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      rst                      = ($urandom_range(0, 199) == 0);
      addr_sel                 = ($urandom_range(0, 9) != 0);
      counter_en               = ($urandom_range(0, 9) < 7);
      adder_en                 = ($urandom_range(0, 3) != 0);
      initial_addr_reg_wen     = ($urandom_range(0, 4) == 0);
      initial_burst_len_reg_en = ($urandom_range(0, 4) == 0);
      initial_addr_in          = ADDR_W'($urandom);
      burst_len_in             = LEN_W'($urandom_range(0, 12));
      single_addr_in           = ADDR_W'($urandom);
      tick();
    end
    rst = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/burst_addr_gen.md
# burst_addr_gen

Burst address generator for the MRAM burst path. It sits directly downstream of the burst controller and holds the initial-address and burst-length registers. It contains the beat counter and the address adder, and provides the single/burst address mux. It produces the per-beat address stream consumed by the address parallel-to-serial output stage. It also returns `stop_signal` to the controller when the programmed number of beats has been issued.

## Interface
Parameters:
- `ADDR_W`, 16, address width
- `LEN_W`, 8, burst-length width
- `ADDR_STEP`, 1, address increment per beat

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge
- `rst`  in  1  reset; synchronous and active-high
- `initial_addr_in`  in  ADDR_W  deserialised start address
- `initial_addr_reg_wen`  in  1  load `initial_addr_in` into the start-address register
- `burst_len_in`  in  LEN_W  deserialised beat count
- `initial_burst_len_reg_en`  in  1  load `burst_len_in` into the length register
- `single_addr_in`  in  ADDR_W  single-transfer serial-path address
- `addr_sel`  in  1  0 = single transfer, 1 = burst
- `counter_en`  in  1  burst start/run request
- `adder_en`  in  1  beat advance enable; low = stall
- `addr_out`  out  ADDR_W  registered address to the PTS output stage
- `addr_valid`  out  1  `addr_out` holds a burst beat this cycle
- `stop_signal`  out  1  one-cycle pulse on the final beat
- `busy`  out  1  FSM not in IDLE

## Operation
Registers:
- `start_reg` loads on `initial_addr_reg_wen`.
- `len_reg` loads on `initial_burst_len_reg_en`.
- Both loads are accepted only in IDLE. Loads in RUN or DONE are ignored.
- If a load and a burst start occur in the same cycle, the start uses the value being written (bypass).

FSM states: IDLE, RUN, DONE.
- **IDLE to RUN:** when `counter_en`=1, `addr_sel`=1 and effective length ≠ 0.
  - `cur_addr` <= effective start.
  - `beat_cnt` <= 0.
- **IDLE to DONE:** when `counter_en`=1, `addr_sel`=1 and effective length = 0.
  - `stop_signal` pulses.
  - No beats are issued.
- **RUN, `adder_en`=1 (beat):**
  - `addr_out` <= `cur_addr`, `addr_valid` <= 1.
  - `cur_addr` <= `cur_addr` + `ADDR_STEP`, modulo 2^ADDR_W (wraps silently).
  - `beat_cnt` <= `beat_cnt`+1.
  - If `beat_cnt` = `len_reg`−1, then `stop_signal` <= 1 and the FSM goes to DONE.
- **RUN, `adder_en`=0 (stall):**
  - `addr_valid` <= 0.
  - `cur_addr`, `beat_cnt` and `addr_out` hold.
- **DONE to IDLE:** when `counter_en`=0. DONE holds while `counter_en`=1, so a held request cannot restart a burst.
- **Abort:** `addr_sel`=0 in RUN sends the FSM to IDLE next edge. There is no `stop_signal` and `addr_valid` <= 0.
- **Single-transfer mode:** `addr_sel`=0 in IDLE.
  - `addr_out` <= `single_addr_in` every cycle, with `addr_valid` = 0.
  - `counter_en` is ignored.
- **Output hold:** `addr_sel`=1 in IDLE or DONE holds `addr_out`.

Width rules:
- `beat_cnt` is LEN_W bits wide.
- The maximum burst is 2^LEN_W−1 beats.
- Length 0 means zero beats.

## Timing
- On `rst`=1 at a clock edge:
  - FSM goes to IDLE.
  - `start_reg`, `len_reg`, `cur_addr`, `beat_cnt` = 0.
  - `addr_out` = 0, `addr_valid` = 0, `stop_signal` = 0, `busy` = 0.
- Reset mid-burst behaves identically: no stop pulse, and the next cycle is IDLE.
- Latency:
  - Edge E0 samples `counter_en`=1 and the FSM enters RUN.
  - If `adder_en`=1 at E1, the first beat is visible after E1 (two edges from request).
  - After that, one beat per cycle while `adder_en`=1.
- `stop_signal` is asserted in the same cycle as the last `addr_valid`, for exactly one cycle.
- `busy` goes high the cycle after the start edge. It goes low the cycle after DONE to IDLE.
- All outputs are registered; no combinational paths from inputs to outputs.

## Test plan
- **Basic burst:** load start 0x0100, len 4, `addr_sel`=1, `counter_en`=1, `adder_en`=1 held.
  - Expect `addr_out` 0x0100, 0x0101, 0x0102, 0x0103 on 4 consecutive valid cycles, starting 2 edges after the request.
  - Expect `stop_signal` with 0x0103, then DONE.
  - Expect IDLE one cycle after `counter_en` drops.
- **Wrap and stall:** start 0xFFFE, len 3, `adder_en` low for 2 cycles after the first beat.
  - Expect 0xFFFE, then 2 cycles with `addr_valid`=0, then 0xFFFF, 0x0000.
  - Expect `stop_signal` on 0x0000.
- **Zero length:** len 0, start request.
  - Expect `stop_signal` pulse and no `addr_valid`.
  - Expect `busy` high until `counter_en`=0.
- **Single mode and bypass:**
  - `addr_sel`=0, `single_addr_in`=0x1234: expect `addr_out`=0x1234 one cycle later, `addr_valid`=0, and `counter_en` ignored.
  - Then write len=2 in the same cycle as the start: expect exactly 2 beats.
- **Abort and reset:** len 10.
  - Drop `addr_sel` after beat 3: expect IDLE next edge, no `stop_signal`, and `start_reg`/`len_reg` writes accepted again.
  - Repeat with `rst` after beat 5: expect all outputs 0 next edge.
- **Locked registers:** write new start/len during RUN.
  - Expect the current burst to be unaffected.
  - Expect the next burst to use the old values.
